// File: rtl/program_memory_loader.sv
// Run-time loadable instruction memory for the pipelined CPU: a host streams a program in over
// valid/ready, and the fetch side reads it back with a registered one-cycle latency.
module program_memory_loader #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 30,
   parameter int DEPTH = 256,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_INSTR = 30'h000000AA,
   localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iReadEnable,
   input  logic [ADDR_WIDTH-1:0] iAddress,
   output logic [DATA_WIDTH-1:0] oInstruction,
   output logic                  oValid,
   input  logic                  iLoadStart,
   input  logic                  iLoadValid,
   input  logic [DATA_WIDTH-1:0] iLoadData,
   input  logic                  iLoadLast,
   output logic                  oLoadReady,
   output logic [CNT_WIDTH-1:0]  oLoadCount,
   output logic                  oLoadDone,
   output logic                  oBusy
);

   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0]  instr_q, instr_d;
   logic                   valid_q, valid_d;
   logic                   done_q, done_d;

   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic                   load_ready;
   logic                   accept;
   logic                   fetch_hit;
   logic [CNT_WIDTH-1:0]   count_inc;
   logic [DATA_WIDTH-1:0]  rd_word;

   always_comb begin
      load_ready = (state_q == LOAD) && (count_q < DEPTH_CNT);
      accept     = iLoadValid && load_ready;
      count_inc  = count_q + CNT_WIDTH'(1);
      // Only words below the load count are valid; this also rejects any address >= DEPTH.
      fetch_hit  = (32'(iAddress) < 32'(count_q));
      rd_word    = mem[iAddress[MEM_AW-1:0]];
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      instr_d = instr_q;
      valid_d = valid_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE, RUN: begin
            if (iLoadStart) begin
               state_d = LOAD;
               count_d = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               count_d = count_inc;
               if (iLoadLast || (count_inc == DEPTH_CNT)) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase

      // A fetch while loading is refused so the host never sees a half-written program.
      if (iReadEnable) begin
         if (state_q == LOAD) begin
            valid_d = 1'b0;
            instr_d = DEFAULT_INSTR;
         end else begin
            valid_d = 1'b1;
            instr_d = fetch_hit ? rd_word : DEFAULT_INSTR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         instr_q <= DEFAULT_INSTR;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // No reset on the array: a zero count already hides whatever it holds.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[count_q[MEM_AW-1:0]] <= iLoadData;
      end
   end

   assign oInstruction = instr_q;
   assign oValid       = valid_q;
   assign oLoadReady   = load_ready;
   assign oLoadCount   = count_q;
   assign oLoadDone    = done_q;
   assign oBusy        = (state_q == LOAD);

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed self-checking bench for program_memory_loader: reset, load, backpressure,
// stall, full load, reload with an in-flight fetch, and reset during a load.
module tb_program_memory_loader;

   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 30;
   localparam int DEPTH = 256;
   localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
   localparam logic [31:0] DEF = 32'h000000AA;

   logic                  clk;
   logic                  rst_n;
   logic                  iReadEnable;
   logic [ADDR_WIDTH-1:0] iAddress;
   logic [DATA_WIDTH-1:0] oInstruction;
   logic                  oValid;
   logic                  iLoadStart;
   logic                  iLoadValid;
   logic [DATA_WIDTH-1:0] iLoadData;
   logic                  iLoadLast;
   logic                  oLoadReady;
   logic [CNT_WIDTH-1:0]  oLoadCount;
   logic                  oLoadDone;
   logic                  oBusy;

   int testCount = 0;
   int failCount = 0;

   program_memory_loader #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH(DEPTH),
      .DEFAULT_INSTR(30'h000000AA)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .iReadEnable(iReadEnable),
      .iAddress(iAddress),
      .oInstruction(oInstruction),
      .oValid(oValid),
      .iLoadStart(iLoadStart),
      .iLoadValid(iLoadValid),
      .iLoadData(iLoadData),
      .iLoadLast(iLoadLast),
      .oLoadReady(oLoadReady),
      .oLoadCount(oLoadCount),
      .oLoadDone(oLoadDone),
      .oBusy(oBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic re, input logic [15:0] addr, input logic start,
                                input logic lv, input logic [29:0] data, input logic last);
      iReadEnable = re;
      iAddress    = addr;
      iLoadStart  = start;
      iLoadValid  = lv;
      iLoadData   = data;
      iLoadLast   = last;
   endtask

   task automatic fetchCheck(input string tag, input logic [15:0] addr, input logic [31:0] expected);
      applyStimulus(1'b1, addr, 1'b0, 1'b0, '0, 1'b0);
      tick();
      checkOutput(tag, 32'(oInstruction), expected);
      checkOutput({tag, "_valid"}, 32'(oValid), 32'd1);
   endtask

   task automatic checkIdleLoader(input string tag, input logic [31:0] cnt);
      checkOutput({tag, "_count"}, 32'(oLoadCount), cnt);
      checkOutput({tag, "_busy"}, 32'(oBusy), 32'd0);
      checkOutput({tag, "_ready"}, 32'(oLoadReady), 32'd0);
   endtask

   logic [29:0] wordsA [4];
   logic [29:0] wordsB [5];
   logic        validPattern [20];

   initial begin
      wordsA = '{30'h0A0A0A0, 30'h0A1A1A1, 30'h0A2A2A2, 30'h0A3A3A3};
      wordsB = '{30'h0B00001, 30'h0B00002, 30'h0B00003, 30'h0B00004, 30'h0B00005};
      validPattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      rst_n = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      tick();
      tick();

      // T1: reset values and a default fetch
      checkOutput("rst_instr", 32'(oInstruction), DEF);
      checkOutput("rst_valid", 32'(oValid), 32'd0);
      checkOutput("rst_done", 32'(oLoadDone), 32'd0);
      checkIdleLoader("rst", 32'd0);
      rst_n = 1'b1;
      fetchCheck("t1_fetch0", 16'd0, DEF);
      checkIdleLoader("t1", 32'd0);

      // T2: iLoadLast without valid does nothing, then load four words
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      tick();
      checkOutput("t2_busy", 32'(oBusy), 32'd1);
      checkOutput("t2_ready", 32'(oLoadReady), 32'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 30'h3FFFFFFF, 1'b1);
      tick();
      checkOutput("t2_lastnovalid_count", 32'(oLoadCount), 32'd0);
      checkOutput("t2_lastnovalid_busy", 32'(oBusy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1, wordsA[i], (i == 3));
         tick();
         checkOutput($sformatf("t2_done_w%0d", i), 32'(oLoadDone), (i == 3) ? 32'd1 : 32'd0);
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      checkIdleLoader("t2_run", 32'd4);
      tick();
      checkOutput("t2_done_after", 32'(oLoadDone), 32'd0);
      for (int i = 0; i < 4; i++) begin
         fetchCheck($sformatf("t2_fetch%0d", i), 16'(i), 32'(wordsA[i]));
      end
      fetchCheck("t2_fetch4", 16'd4, DEF);

      // T3: reload with a gappy valid pattern, then a stall
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      tick();
      begin
         int sent = 0;
         for (int c = 0; c < 20 && sent < 5; c++) begin
            applyStimulus(1'b0, '0, 1'b0, validPattern[c], wordsB[sent], (sent == 4));
            tick();
            if (validPattern[c]) sent++;
         end
         checkOutput("t3_all_sent", 32'(sent), 32'd5);
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      checkIdleLoader("t3_run", 32'd5);
      for (int i = 0; i < 5; i++) begin
         fetchCheck($sformatf("t3_fetch%0d", i), 16'(i), 32'(wordsB[i]));
      end
      fetchCheck("t3_pre_stall", 16'd1, 32'(wordsB[1]));
      applyStimulus(1'b0, 16'd3, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("t3_stall%0d", i), 32'(oInstruction), 32'(wordsB[1]));
         checkOutput($sformatf("t3_stall%0d_valid", i), 32'(oValid), 32'd1);
      end

      // T4: fill all DEPTH words without iLoadLast
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      tick();
      begin
         int doneSeen = 0;
         for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) checkOutput("t4_ready_before_last", 32'(oLoadReady), 32'd1);
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 30'h2000000 + 30'(i), 1'b0);
            tick();
            if (oLoadDone) doneSeen++;
         end
         checkOutput("t4_ready_after_full", 32'(oLoadReady), 32'd0);
         checkOutput("t4_count", 32'(oLoadCount), 32'd256);
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 30'h3FFFFFF, 1'b0);
         tick();
         if (oLoadDone) doneSeen++;
         tick();
         if (oLoadDone) doneSeen++;
         checkOutput("t4_done_pulses", 32'(doneSeen), 32'd1);
         checkOutput("t4_count_held", 32'(oLoadCount), 32'd256);
      end
      fetchCheck("t4_fetch255", 16'd255, 32'h020000FF);
      fetchCheck("t4_fetch300", 16'd300, DEF);
      fetchCheck("t4_fetch0", 16'd0, 32'h02000000);

      // T5: reload while a fetch is in flight
      applyStimulus(1'b1, 16'd10, 1'b1, 1'b0, '0, 1'b0);
      tick();
      checkOutput("t5_inflight", 32'(oInstruction), 32'h0200000A);
      checkOutput("t5_inflight_valid", 32'(oValid), 32'd1);
      checkOutput("t5_busy", 32'(oBusy), 32'd1);
      checkOutput("t5_count_clr", 32'(oLoadCount), 32'd0);
      applyStimulus(1'b1, 16'd0, 1'b0, 1'b0, '0, 1'b0);
      tick();
      checkOutput("t5_load_fetch", 32'(oInstruction), DEF);
      checkOutput("t5_load_fetch_valid", 32'(oValid), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 30'h0C0C0C0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 30'h0C1C1C1, 1'b1);
      tick();
      checkOutput("t5_done", 32'(oLoadDone), 32'd1);
      checkIdleLoader("t5_run", 32'd2);
      fetchCheck("t5_fetch0", 16'd0, 32'h00C0C0C0);
      fetchCheck("t5_fetch1", 16'd1, 32'h00C1C1C1);
      fetchCheck("t5_fetch2", 16'd2, DEF);

      // T6: asynchronous reset in the middle of a load
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 30'h0D00000 + 30'(i), 1'b0);
         tick();
      end
      checkOutput("t6_count_pre", 32'(oLoadCount), 32'd3);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_instr", 32'(oInstruction), DEF);
      checkOutput("t6_valid", 32'(oValid), 32'd0);
      checkOutput("t6_done", 32'(oLoadDone), 32'd0);
      checkIdleLoader("t6", 32'd0);
      tick();
      rst_n = 1'b1;
      fetchCheck("t6_fetch0", 16'd0, DEF);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
